// File: rtl/mouse_dev_pkg.sv
// Shared states and byte codes for the PS/2 mouse device FSM.
// Optional MOUSE_DEV_RESEND_EN enables 0xFE resend handling.
package mouse_dev_pkg;

  typedef enum logic [3:0] {
    BAT_AA,
    BAT_ID,
    DISABLED,
    ACK,
    STREAM,
    PKT0,
    PKT1,
    PKT2,
    WAIT_SENT
  } state_t;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_DISABLE = 8'hF5;
  localparam logic [7:0] CMD_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_ERROR   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_DEV_ID  = 8'h00;

  function automatic logic is_stream(state_t s);
    return s inside {STREAM, PKT0, PKT1, PKT2};
  endfunction

  // Where a byte-send state goes once its byte is out.
  function automatic state_t next_send(state_t s);
    unique case (s)
      BAT_AA:  return BAT_ID;
      BAT_ID:  return DISABLED;
      PKT0:    return PKT1;
      PKT1:    return PKT2;
      default: return STREAM;
    endcase
  endfunction

endpackage

// File: rtl/mouse_move_accum.sv
// One-axis 9-bit signed movement accumulator with saturation
// at -256/+255 and a sticky overflow flag.
module mouse_move_accum (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] delta,
  output logic [8:0] acc,
  output logic       ovf
);

  logic [9:0] sum;

  assign sum = {acc[8], acc} + {{2{delta[7]}}, delta};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= add ? {delta[7], delta} : 9'd0;
      ovf <= 1'b0;
    end else if (add) begin
      if (sum[9] ^ sum[8]) begin
        acc <= sum[9] ? 9'h100 : 9'h0FF;
        ovf <= 1'b1;
      end else begin
        acc <= sum[8:0];
      end
    end
  end

endmodule

// File: rtl/mouse_device_sm.sv
// PS/2 mouse device-side protocol FSM: BAT, command acks, stream packets.
// Define MOUSE_DEV_RESEND_EN to answer 0xFE with the last byte sent.
module mouse_device_sm
  import mouse_dev_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 500000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_READY,
  input  logic [7:0] CMD_BYTE,
  input  logic [1:0] CMD_ERROR,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  input  logic       MOVE_VALID,
  input  logic [7:0] MOVE_DX,
  input  logic [7:0] MOVE_DY,
  input  logic [2:0] BUTTONS,
  output logic       STREAM_EN
);

  localparam int CW =
    (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  state_t state, ret;
  logic   mode_stream;
  logic   pend_v, pend_err;
  logic [7:0] pend_byte;
  logic [7:0] snap_dx, snap_dy;
  logic [2:0] last_btn;
  logic [CW-1:0] cnt;
  logic   clr_q;
`ifdef MOUSE_DEV_RESEND_EN
  logic [7:0] last_sent;
`endif

  logic [8:0] acc_x, acc_y;
  logic       ovf_x, ovf_y;
  logic       acc_add, acc_clr;
  logic       period_done, snap, svc;
  logic       c_v, c_err;
  logic [7:0] c_byte, rsp, status;
  state_t     rsp_ret;
  logic       rsp_mode, rsp_clr;

  assign period_done = cnt == CW'(SAMPLE_PERIOD - 1);
  assign acc_add = MOVE_VALID & STREAM_EN;
  assign acc_clr = snap | clr_q;
  assign status = {ovf_y, ovf_x, acc_y[8], acc_x[8],
                   1'b1, BUTTONS};

  mouse_move_accum u_acc_x (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (acc_clr),
    .add   (acc_add),
    .delta (MOVE_DX),
    .acc   (acc_x),
    .ovf   (ovf_x)
  );

  mouse_move_accum u_acc_y (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (acc_clr),
    .add   (acc_add),
    .delta (MOVE_DY),
    .acc   (acc_y),
    .ovf   (ovf_y)
  );

  // A fresh command wins over the latched one.
  always_comb begin
    c_v      = CMD_READY | pend_v;
    c_byte   = CMD_READY ? CMD_BYTE : pend_byte;
    c_err    = CMD_READY ? (CMD_ERROR != 2'b00) : pend_err;
    rsp      = RSP_ACK;
    rsp_ret  = mode_stream ? STREAM : DISABLED;
    rsp_mode = mode_stream;
    rsp_clr  = 1'b0;
    unique case (1'b1)
      c_err: rsp = RSP_ERROR;
      !c_err && c_byte == CMD_RESET: begin
        rsp_ret  = BAT_AA;
        rsp_mode = 1'b0;
        rsp_clr  = 1'b1;
      end
      !c_err && c_byte == CMD_ENABLE: begin
        rsp_ret  = STREAM;
        rsp_mode = 1'b1;
      end
      !c_err && c_byte == CMD_DISABLE: begin
        rsp_ret  = DISABLED;
        rsp_mode = 1'b0;
      end
`ifdef MOUSE_DEV_RESEND_EN
      !c_err && c_byte == CMD_RESEND: rsp = last_sent;
`endif
      default: ;
    endcase
  end

  assign svc = c_v && (state == STREAM || state == DISABLED ||
                       (state == WAIT_SENT && BYTE_SENT));

  assign snap = state == STREAM && !c_v && period_done &&
                (acc_x != 9'd0 || acc_y != 9'd0 ||
                 BUTTONS != last_btn);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= BAT_AA;
      ret          <= DISABLED;
      SEND_BYTE    <= 1'b0;
      BYTE_TO_SEND <= RSP_BAT_OK;
      STREAM_EN    <= 1'b0;
      mode_stream  <= 1'b0;
      pend_v       <= 1'b0;
      pend_err     <= 1'b0;
      pend_byte    <= '0;
      snap_dx      <= '0;
      snap_dy      <= '0;
      last_btn     <= '0;
      cnt          <= '0;
      clr_q        <= 1'b0;
`ifdef MOUSE_DEV_RESEND_EN
      last_sent    <= '0;
`endif
    end else begin
      SEND_BYTE <= 1'b0;
      clr_q     <= 1'b0;
      if (snap) cnt <= '0;
      else if (!period_done) cnt <= cnt + 1'b1;
      if (CMD_READY && !svc) begin
        pend_v    <= 1'b1;
        pend_byte <= CMD_BYTE;
        pend_err  <= CMD_ERROR != 2'b00;
      end
      if (svc) begin
        state        <= ACK;
        ret          <= rsp_ret;
        mode_stream  <= rsp_mode;
        clr_q        <= rsp_clr;
        BYTE_TO_SEND <= rsp;
        STREAM_EN    <= 1'b0;
        pend_v       <= 1'b0;
      end else begin
        unique case (state)
          BAT_AA, BAT_ID, ACK, PKT0, PKT1, PKT2: begin
            SEND_BYTE <= 1'b1;
            state     <= WAIT_SENT;
            if (state != ACK) ret <= next_send(state);
`ifdef MOUSE_DEV_RESEND_EN
            last_sent <= BYTE_TO_SEND;
`endif
          end
          WAIT_SENT: if (BYTE_SENT) begin
            state     <= ret;
            STREAM_EN <= is_stream(ret);
            unique case (ret)
              BAT_AA:  BYTE_TO_SEND <= RSP_BAT_OK;
              BAT_ID:  BYTE_TO_SEND <= RSP_DEV_ID;
              PKT1:    BYTE_TO_SEND <= snap_dx;
              PKT2:    BYTE_TO_SEND <= snap_dy;
              default: ;
            endcase
          end
          STREAM: if (snap) begin
            state        <= PKT0;
            BYTE_TO_SEND <= status;
            snap_dx      <= acc_x[7:0];
            snap_dy      <= acc_y[7:0];
            last_btn     <= BUTTONS;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mouse_device_sm.sv
// Directed bench for mouse_device_sm with a 5-cycle byte responder.
// Resend expectation follows MOUSE_DEV_RESEND_EN.
module tb_mouse_device_sm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CMD_READY = 1'b0;
  logic [7:0] CMD_BYTE = '0;
  logic [1:0] CMD_ERROR = '0;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       MOVE_VALID = 1'b0;
  logic [7:0] MOVE_DX = '0;
  logic [7:0] MOVE_DY = '0;
  logic [2:0] BUTTONS = '0;
  logic       STREAM_EN;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx[$];
  logic [7:0] expq[$];

  typedef struct {
    logic [7:0] cmd;
    logic [1:0] err;
    logic [7:0] rsp;
    logic       en;
  } vec_t;
  vec_t tbl[8];

  mouse_device_sm #(.SAMPLE_PERIOD(64)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CMD_READY    (CMD_READY),
    .CMD_BYTE     (CMD_BYTE),
    .CMD_ERROR    (CMD_ERROR),
    .SEND_BYTE    (SEND_BYTE),
    .BYTE_TO_SEND (BYTE_TO_SEND),
    .BYTE_SENT    (BYTE_SENT),
    .MOVE_VALID   (MOVE_VALID),
    .MOVE_DX      (MOVE_DX),
    .MOVE_DY      (MOVE_DY),
    .BUTTONS      (BUTTONS),
    .STREAM_EN    (STREAM_EN)
  );

  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (SEND_BYTE === 1'b1) begin
        rx.push_back(BYTE_TO_SEND);
        repeat (4) @(posedge CLK);
        #1 BYTE_SENT = 1'b1;
        @(posedge CLK);
        #1 BYTE_SENT = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic [1:0] e);
    @(posedge CLK);
    #1 CMD_READY = 1'b1;
    CMD_BYTE = b;
    CMD_ERROR = e;
    @(posedge CLK);
    #1 CMD_READY = 1'b0;
    CMD_ERROR = 2'b00;
  endtask

  task automatic check_rx(input string nm);
    for (int k = 0; k < 600 && rx.size() < expq.size(); k++)
      @(posedge CLK);
    chk({nm, "_count"}, rx.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < rx.size())
        chk($sformatf("%s[%0d]", nm, i), rx[i], expq[i]);
    rx.delete();
    expq.delete();
    repeat (8) @(posedge CLK);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hE6, 2'b00, 8'hFA, 1'b0};
    tbl[1] = '{8'hF4, 2'b00, 8'hFA, 1'b1};
    tbl[2] = '{8'hF2, 2'b00, 8'hFA, 1'b1};
    tbl[3] = '{8'h00, 2'b01, 8'hFE, 1'b1};
    tbl[4] = '{8'hF5, 2'b00, 8'hFA, 1'b0};
    tbl[5] = '{8'h12, 2'b10, 8'hFE, 1'b0};
`ifdef MOUSE_DEV_RESEND_EN
    tbl[6] = '{8'hFE, 2'b00, 8'hFE, 1'b0};
`else
    tbl[6] = '{8'hFE, 2'b00, 8'hFA, 1'b0};
`endif
    tbl[7] = '{8'hF4, 2'b00, 8'hFA, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_send", SEND_BYTE, 1'b0);
    chk("rst_byte", BYTE_TO_SEND, 8'hAA);
    chk("rst_en", STREAM_EN, 1'b0);
    RESET = 1'b0;

    expq.push_back(8'hAA);
    expq.push_back(8'h00);
    check_rx("boot");
    repeat (30) @(posedge CLK);
    #1;
    chk("boot_quiet", rx.size(), 0);
    chk("boot_en", STREAM_EN, 1'b0);

    for (int v = 0; v < 8; v++) begin
      send_cmd(tbl[v].cmd, tbl[v].err);
      expq.push_back(tbl[v].rsp);
      check_rx($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_en", v), STREAM_EN, tbl[v].en);
    end

    // Move first, then press left: single packet with both.
    @(posedge CLK);
    #1 MOVE_VALID = 1'b1;
    MOVE_DX = 8'd3;
    MOVE_DY = 8'hFE;
    @(posedge CLK);
    #1 MOVE_VALID = 1'b0;
    BUTTONS = 3'b001;
    expq.push_back(8'h29);
    expq.push_back(8'h03);
    expq.push_back(8'hFE);
    check_rx("pkt_a");
    chk("pkt_a_en", STREAM_EN, 1'b1);

    repeat (70) @(posedge CLK);
    #1 BUTTONS = 3'b000;
    MOVE_DX = 8'd100;
    MOVE_DY = 8'd0;
    MOVE_VALID = 1'b1;
    repeat (20) @(posedge CLK);
    #1 MOVE_VALID = 1'b0;
    expq.push_back(8'h08);
    expq.push_back(8'h00);
    expq.push_back(8'h00);
    expq.push_back(8'h48);
    expq.push_back(8'hFF);
    expq.push_back(8'h00);
    check_rx("pkt_ovf");

    repeat (70) @(posedge CLK);
    #1 MOVE_VALID = 1'b1;
    MOVE_DX = 8'd1;
    MOVE_DY = 8'd1;
    @(posedge CLK);
    #1 MOVE_VALID = 1'b0;
    for (int k = 0; k < 200 && rx.size() < 2; k++)
      @(posedge CLK);
    send_cmd(8'hFF, 2'b00);
    expq.push_back(8'h08);
    expq.push_back(8'h01);
    expq.push_back(8'hFA);
    expq.push_back(8'hAA);
    expq.push_back(8'h00);
    check_rx("ff_mid");
    repeat (10) @(posedge CLK);
    #1;
    chk("ff_en", STREAM_EN, 1'b0);
    chk("ff_quiet", rx.size(), 0);

    @(posedge CLK);
    #1 MOVE_VALID = 1'b1;
    MOVE_DX = 8'd50;
    MOVE_DY = 8'd50;
    repeat (3) @(posedge CLK);
    #1 MOVE_VALID = 1'b0;
    send_cmd(8'hF4, 2'b00);
    expq.push_back(8'hFA);
    check_rx("dis_en");
    repeat (100) @(posedge CLK);
    #1;
    chk("dis_ignored", rx.size(), 0);
    chk("dis_stream_en", STREAM_EN, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
